// File: rtl/adder_lab_pkg.sv
// Shared types and helpers for the adder lab blocks: the checker state
// encoding, sweep length and the reference sum used as the golden result.
package adder_lab_pkg;

    // Widest operand the reference sum supports; larger W needs this raised.
    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of {cin, x, y} vectors in an exhaustive sweep of a W-bit adder.
    function automatic int unsigned SWEEP_LEN(input int unsigned w);
        return 32'd1 << (2 * w + 1);
    endfunction

    // Golden x + y + cin at MAX_W+1 bits; callers zero-extend operands and
    // keep the low W+1 bits.
    function automatic logic [MAX_W:0] expected_sum(
        input logic             cin,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge ck) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/full_adder_checker.sv
// Response checker for the adder labs: compares each {cout, s} against the
// arithmetic sum of its {cin, x, y}, checks sweep order and gives a verdict.
module full_adder_checker
    import adder_lab_pkg::*;
#(
    parameter int W     = 1,
    parameter int ERR_W = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic             cin,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             cout,
    input  logic [W-1:0]     s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2*W:0]     fail_vec,
    output logic [W:0]       fail_got
);

    localparam int VW = 2 * W + 1;
    localparam logic [VW-1:0] LAST_IDX = VW'(SWEEP_LEN(W) - 1);

    state_t          state;
    logic [VW-1:0]   idx;
    logic            have_fail;

    logic [VW-1:0]   vec;
    logic [W:0]      got;
    logic [MAX_W:0]  sum_full;
    logic [W:0]      expected;
    logic            arm;
    logic            accept;
    logic            mismatch;
    logic            out_of_order;

    // NOTE: every combinational output gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        vec          = {cin, x, y};
        got          = {cout, s};
        sum_full     = expected_sum(cin, MAX_W'(x), MAX_W'(y));
        expected     = sum_full[W:0];
        arm          = (state != CHECK) && start;
        accept       = (state == CHECK) && vld;
        mismatch     = accept && (got != expected);
        out_of_order = accept && (vec != idx);
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .ck  (ck),
        .rst (rst),
        .clr (arm),
        .inc (mismatch),
        .cnt (err_cnt)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            have_fail <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            seq_err   <= 1'b0;
            fail_vec  <= '0;
            fail_got  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= CHECK;
                        idx       <= '0;
                        have_fail <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        seq_err   <= 1'b0;
                        fail_vec  <= '0;
                        fail_got  <= '0;
                    end
                end
                CHECK: begin
                    if (vld) begin
                        idx <= idx + 1'b1;
                        if (out_of_order) begin
                            seq_err <= 1'b1;
                        end
                        if (mismatch && !have_fail) begin
                            have_fail <= 1'b1;
                            fail_vec  <= vec;
                            fail_got  <= got;
                        end
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // Fold in the last vector's own checks, which the
                            // registered flags only pick up at this same edge.
                            pass  <= (err_cnt == '0) && !mismatch
                                     && !seq_err && !out_of_order;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/full_adder_checker.md
# full_adder_checker

Self-checking response end for the adder labs. It consumes the exhaustive `{cin, x, y}` stimulus sweep together with the adder's `{cout, s}` result, and compares each result against the arithmetic sum. It also checks that the vectors arrive in ascending order, counts mismatches, captures the first failure and reports a pass/fail verdict. It sits beside the adder under test, in simulation or on the board, opposite the stimulus counter. It is parameterised so the same block checks the 1-bit full adder and wider ripple-carry adders.

## Interface
Parameters:
- `W`, default 1: operand width of the adder under test. The sweep length is 2^(2W+1) vectors.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `ck`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms a new sweep.
- `vld`  in  1  `cin`/`x`/`y`/`cout`/`s` are valid this cycle.
- `cin`  in  1  stimulus carry-in.
- `x`  in  W  stimulus operand.
- `y`  in  W  stimulus operand.
- `cout`  in  1  adder carry-out.
- `s`  in  W  adder sum.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete; sticky.
- `pass`  out  1  verdict; valid while `done`=1.
- `seq_err`  out  1  sticky; a vector arrived out of order.
- `err_cnt`  out  ERR_W  count of result mismatches; saturates.
- `fail_vec`  out  2W+1  `{cin, x, y}` of the first mismatch.
- `fail_got`  out  W+1  `{cout, s}` observed at the first mismatch.

## Operation
- States: IDLE, CHECK, DONE.
- IDLE, `start`=1 -> CHECK. Clears `idx`, `err_cnt`, `seq_err`, `fail_vec`, `fail_got`, the first-fail flag, `done` and `pass`.
- DONE, `start`=1 -> CHECK, with the same clears as from IDLE.
- CHECK, `start` -> ignored.
- IDLE/DONE, `vld` -> ignored; nothing updates.
- CHECK, each cycle with `vld`=1 (an accepted vector):
  - expected result = `x + y + cin`, computed at W+1 bits, zero-extended.
  - If `{cout, s}` != expected: `err_cnt` increments, holding at 2^ERR_W−1. If this is the first mismatch of the sweep, latch `fail_vec` = `{cin,x,y}` and `fail_got` = `{cout,s}`.
  - If `{cin,x,y}` != `idx`: set `seq_err`. Sequence errors do not touch `err_cnt` or the fail capture.
  - `idx` increments, width 2W+1.
  - If `idx` was 2^(2W+1)−1: go to DONE.
- CHECK, `vld`=0: hold all state; gaps of any length are legal.
- DONE is entered exactly after 2^(2W+1) accepted vectors, regardless of sequence errors.
- `pass` = (`err_cnt`==0) && !`seq_err`. It includes the final vector's checks and is driven only in DONE; otherwise it is 0.
- `busy` = 1 in CHECK only.
- Producer contract: the `{cout, s}` presented with a vector is the adder's settled response to that same vector in the same cycle. A pipelined adder must be realigned by the producer.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `busy`, `done`, `pass`, `seq_err`, `err_cnt`, `fail_vec`, `fail_got` all 0.
- `start` at edge n: `busy`=1 from n+1. A vector with `vld` at edge n+1 is the first accepted.
- Last vector accepted at edge m: `done`=1, `pass` valid and `busy`=0 from m+1.
- Error updates: a mismatch accepted at edge m is visible on `err_cnt`/`fail_*` from m+1.
- `start` and `vld` both high in IDLE/DONE: the sweep arms and that vector is dropped.
- `rst` mid-sweep: all state returns to reset values at the next edge; a new `start` is required.
- `rst` has priority over `start`.

## Structure
- Shared package `adder_lab_pkg` holds:
  - the state enum (IDLE/CHECK/DONE);
  - the `SWEEP_LEN(W)` constant function = 1 << (2W+1);
  - the expected-sum function.
- One natural sub-module, `sat_counter`: width parameter, with clear, increment and saturate. Used for `err_cnt`.
- `idx` is a plain wrapping counter inside the checker.

## Test plan
1. Correct full adder, W=1, `start`, then vectors 0..7 on consecutive cycles -> `done`=1 one cycle after vector 7; `pass`=1, `err_cnt`=0, `seq_err`=0.
2. Same as 1, but `s` inverted only on vector 3'b101 -> `err_cnt`=1, `fail_vec`=3'b101, `fail_got`=2'b11 (expected 2'b10), `pass`=0.
3. Correct adder with `vld` low for 3 cycles between each pair of vectors -> `done` only after the 8th accepted vector; `pass`=1.
4. Vector 3 replaced by a repeat of vector 2 -> `seq_err`=1, `err_cnt`=0, `done` after 8 accepts, `pass`=0.
5. `ERR_W`=2, `{cout,s}` stuck at 2'b11 -> `err_cnt` saturates at 3, `fail_vec`=3'b000, `pass`=0. Then `start` again with a correct adder -> all clears, `pass`=1.
6. `rst` after 4 vectors -> all outputs 0, IDLE; `vld` without `start` has no effect. W=2 full sweep (32 vectors) with a correct adder -> `pass`=1.
